dkong_scandoubler: RTL

- Video output stage downstream of the H/V counter and colour mixer.
- Captures each 15.6 kHz input line (R3 G3 B2, 6.144 MHz pixels, 4 I_CLK per pixel) into a ping-pong line buffer.
- Replays the previous line twice at double pixel rate to give a 31 kHz progressive signal for VGA/HDMI scalers.
- Runs entirely in the 24.576 MHz I_CLK domain; input timing is recovered from the counter's sync/blank strobes.

---
 rtl/dkong_scandoubler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dkong_scandoubler.sv
// Line-doubling video output stage: captures 15.6 kHz lines into a ping-pong buffer and
// replays each twice at 31 kHz. Define DKONG_SCANLINE_EN to dim the second replay.
module dkong_scandoubler #(
    parameter int unsigned MAX_W     = 256,
    parameter int unsigned LINE_LEN  = 768,
    parameter int unsigned ACT_START = 192,
    parameter int unsigned HS_START  = 24,
    parameter int unsigned HS_W      = 92
) (
    input  logic       I_CLK,
    input  logic       RST_n,
    input  logic [2:0] I_R,
    input  logic [2:0] I_G,
    input  logic [1:0] I_B,
    input  logic       I_H_BLANKn,
    input  logic       I_V_BLANKn,
    input  logic       I_H_SYNCn,
    input  logic       I_V_SYNCn,
    output logic [2:0] O_R,
    output logic [2:0] O_G,
    output logic [1:0] O_B,
    output logic       O_H_SYNCn,
    output logic       O_V_SYNCn,
    output logic       O_BLANKn,
    output logic       O_CE,
    output logic       O_LINE
);

    localparam int unsigned AW = $clog2(MAX_W);
    localparam int unsigned XW = AW + 1;
    localparam int unsigned HW = $clog2(LINE_LEN);

    localparam logic [XW-1:0] X_MAX  = XW'(MAX_W);
    localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] HS_LO  = HW'(HS_START);
    localparam logic [HW-1:0] HS_HI  = HW'(HS_START + HS_W);
    localparam logic [HW:0]   ACT_X  = (HW + 1)'(ACT_START);

    logic          sync_q;
    logic          hs_fall;
    logic [1:0]    in_ph_q;
    logic [XW-1:0] wr_x_q;
    logic [XW-1:0] act_len_q;
    logic          bank_q;
    logic          vbl_q;
    logic [HW-1:0] o_h_q;
    logic          line_q;
    logic          wr_en;

    assign hs_fall = sync_q & ~I_H_SYNCn;
    assign wr_en   = (in_ph_q == 2'd3) && I_H_BLANKn && !hs_fall && (wr_x_q != X_MAX);

    // Input side: phase, write pointer, bank swap and output line counter.
    always_ff @(posedge I_CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q    <= 1'b1;
            in_ph_q   <= '0;
            wr_x_q    <= '0;
            act_len_q <= '0;
            bank_q    <= 1'b0;
            vbl_q     <= 1'b0;
            o_h_q     <= '0;
            line_q    <= 1'b0;
        end else begin
            sync_q <= I_H_SYNCn;
            if (hs_fall) begin
                in_ph_q   <= '0;
                wr_x_q    <= '0;
                act_len_q <= wr_x_q;
                bank_q    <= ~bank_q;
                vbl_q     <= I_V_BLANKn;
                o_h_q     <= '0;
                line_q    <= 1'b0;
            end else begin
                in_ph_q <= in_ph_q + 2'd1;
                if (wr_en) wr_x_q <= wr_x_q + XW'(1);
                if (o_h_q == H_LAST) begin
                    o_h_q  <= '0;
                    line_q <= ~line_q;
                end else begin
                    o_h_q <= o_h_q + HW'(1);
                end
            end
        end
    end

    logic [HW:0]   h_ext;
    logic [HW:0]   h_rel;
    logic [HW:0]   win_end;
    logic          act_win;
    logic [AW-1:0] rd_addr;

    assign h_ext   = {1'b0, o_h_q};
    assign h_rel   = h_ext - ACT_X;
    assign win_end = ACT_X + (HW + 1)'({act_len_q, 1'b0});
    assign act_win = (h_ext >= ACT_X) && (h_ext < win_end);
    assign rd_addr = h_rel[AW:1];

    logic [7:0] mem [2*MAX_W];
    logic [7:0] rd_q;

    always_ff @(posedge I_CLK) begin
        if (wr_en) mem[{bank_q, wr_x_q[AW-1:0]}] <= {I_R, I_G, I_B};
        rd_q <= mem[{~bank_q, rd_addr}];
    end

    // First pipeline stage, aligned with the registered memory read.
    logic act_q;
    logic hsn_q;
    logic ce_q;
    logic line1_q;

    always_ff @(posedge I_CLK or negedge RST_n) begin
        if (!RST_n) begin
            act_q   <= 1'b0;
            hsn_q   <= 1'b1;
            ce_q    <= 1'b0;
            line1_q <= 1'b0;
        end else begin
            act_q   <= act_win;
            hsn_q   <= !((o_h_q >= HS_LO) && (o_h_q < HS_HI));
            ce_q    <= o_h_q[0];
            line1_q <= line_q;
        end
    end

    logic [7:0] pix_out;

`ifdef DKONG_SCANLINE_EN
    always_comb begin
        pix_out = rd_q;
        if (line1_q) pix_out = {1'b0, rd_q[7:6], 1'b0, rd_q[4:3], 1'b0, rd_q[1]};
    end
`else
    assign pix_out = rd_q;
`endif

    always_ff @(posedge I_CLK or negedge RST_n) begin
        if (!RST_n) begin
            O_R       <= '0;
            O_G       <= '0;
            O_B       <= '0;
            O_BLANKn  <= 1'b0;
            O_H_SYNCn <= 1'b1;
            O_V_SYNCn <= 1'b1;
            O_CE      <= 1'b0;
            O_LINE    <= 1'b0;
        end else begin
            O_R       <= act_q ? pix_out[7:5] : 3'd0;
            O_G       <= act_q ? pix_out[4:2] : 3'd0;
            O_B       <= act_q ? pix_out[1:0] : 2'd0;
            O_BLANKn  <= act_q & vbl_q;
            O_H_SYNCn <= hsn_q;
            O_CE      <= ce_q;
            O_LINE    <= line1_q;
            if (o_h_q == '0) O_V_SYNCn <= I_V_SYNCn;
        end
    end

endmodule
